// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer between the fetch stage and a variable-latency memory port.
// One request outstanding; redirects drop stale responses; decode stalls park data in HOLD.
module if_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter int unsigned       TIMEOUT  = 255,
  parameter int unsigned       CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              redirect,
  input  logic              stall_in,
  output logic              fetch_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_data,
  input  logic              mem_resp_err,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fault
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHold} state_e;

  state_e              state_q, state_d;
  logic                req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                inst_valid_q, inst_valid_d;
  logic [INST_W-1:0]   inst_out_q, inst_out_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                fault_q, fault_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [INST_W-1:0]   hold_data_q, hold_data_d;
  logic                timeout_hit;

  // Fires on the cycle whose increment would reach TIMEOUT.
  assign timeout_hit = (cnt_q >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP_INST;
      inst_pc_q    <= '0;
      fault_q      <= 1'b0;
      drop_q       <= 1'b0;
      cnt_q        <= '0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
      drop_q       <= drop_d;
      cnt_q        <= cnt_d;
      hold_data_q  <= hold_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pc_valid && !redirect) state_d = StReq;
      StReq:  if (mem_req_ready) state_d = (drop_q || redirect) ? StDrop : StWait;
      StWait: begin
        if (mem_resp_valid) begin
          if (redirect || mem_resp_err) state_d = StIdle;
          else if (stall_in)            state_d = StHold;
          else                          state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end else if (redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: if (mem_resp_valid || timeout_hit) state_d = StIdle;
      StHold: if (redirect || !stall_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_valid_d  = (state_d == StReq);
    req_addr_d   = req_addr_q;
    inst_valid_d = 1'b0;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    fault_d      = 1'b0;
    drop_d       = 1'b0;
    cnt_d        = cnt_q;
    hold_data_d  = hold_data_q;
    unique case (state_q)
      StIdle: begin
        if (pc_valid && !redirect) req_addr_d = pc_in;
      end
      StReq: begin
        if (mem_req_ready) cnt_d = '0;
        else               drop_d = drop_q | redirect;
      end
      StWait, StDrop: begin
        cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        if (state_q == StWait && mem_resp_valid) begin
          if (redirect) begin
            // stale response, drop silently
          end else if (mem_resp_err) begin
            fault_d = 1'b1;
          end else if (stall_in) begin
            hold_data_d = mem_resp_data;
          end else begin
            inst_valid_d = 1'b1;
            inst_out_d   = mem_resp_data;
            inst_pc_d    = req_addr_q;
          end
        end else if (!mem_resp_valid && timeout_hit) begin
          fault_d = 1'b1;
        end
      end
      StHold: begin
        // req_addr_q is stable until the next IDLE launch, so it is the held PC.
        if (!redirect && !stall_in) begin
          inst_valid_d = 1'b1;
          inst_out_d   = hold_data_q;
          inst_pc_d    = req_addr_q;
        end
      end
      default: ;
    endcase
  end

  assign fetch_stall   = (state_q != StIdle);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign inst_valid    = inst_valid_q;
  assign inst_out      = inst_out_q;
  assign inst_pc       = inst_pc_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a vector table for single-cycle flows plus
// hand-written sequences for backpressure, decode stall, timeout and mid-flight reset.
module tb_if_fetch_ctrl;

  localparam logic [63:0] A   = 64'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0010_0093;
  localparam logic [31:0] I2  = 32'h0020_0113;
  localparam logic [31:0] I3  = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst, pc_valid, redirect, stall_in, mem_req_ready, mem_resp_valid, mem_resp_err;
  logic [63:0] pc_in;
  logic [31:0] mem_resp_data;
  logic        fetch_stall, mem_req_valid, inst_valid, fault;
  logic [63:0] mem_req_addr, inst_pc;
  logic [31:0] inst_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_valid      (pc_valid),
    .pc_in         (pc_in),
    .redirect      (redirect),
    .stall_in      (stall_in),
    .fetch_stall   (fetch_stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .mem_resp_err  (mem_resp_err),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .fault         (fault)
  );

  typedef struct {
    logic        rst, pv;
    logic [63:0] pc;
    logic        rd, st, rdy, rv;
    logic [31:0] data;
    logic        err;
    logic        e_stall, e_rqv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic pv, logic [63:0] pc, logic rd, logic st, logic rdy,
                              logic rv, logic [31:0] data, logic err, logic es, logic eq,
                              logic [63:0] ea, logic eiv, logic [31:0] ei, logic [63:0] ep,
                              logic ef);
    vec_t v;
    v.rst = r; v.pv = pv; v.pc = pc; v.rd = rd; v.st = st; v.rdy = rdy; v.rv = rv;
    v.data = data; v.err = err; v.e_stall = es; v.e_rqv = eq; v.e_addr = ea; v.e_iv = eiv;
    v.e_inst = ei; v.e_ipc = ep; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive inputs at the falling edge, then sample just after the next rising edge.
  task automatic cyc(input logic r, input logic pv, input logic [63:0] pc, input logic rd,
                     input logic st, input logic rdy, input logic rv, input logic [31:0] d,
                     input logic err);
    @(negedge clk);
    rst = r; pc_valid = pv; pc_in = pc; redirect = rd; stall_in = st;
    mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = d; mem_resp_err = err;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 64'h0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic chk_all(input string tag, input logic es, input logic eq, input logic [63:0] ea,
                         input logic eiv, input logic [31:0] ei, input logic [63:0] ep,
                         input logic ef);
    chk({tag, ".fetch_stall"}, 64'(fetch_stall), 64'(es));
    chk({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'(eq));
    chk({tag, ".mem_req_addr"}, mem_req_addr, ea);
    chk({tag, ".inst_valid"}, 64'(inst_valid), 64'(eiv));
    chk({tag, ".inst_out"}, 64'(inst_out), 64'(ei));
    chk({tag, ".inst_pc"}, inst_pc, ep);
    chk({tag, ".fault"}, 64'(fault), 64'(ef));
  endtask

  initial begin
    rst = 1'b1; pc_valid = 0; pc_in = 0; redirect = 0; stall_in = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
    repeat (2) @(posedge clk);

    //          rst pv pc        rd st rdy rv data           err  stall rqv addr      iv inst ipc     f
    vecs.push_back(mk(1, 0, 64'h0,    0, 0, 0, 0, 32'h0,        0,   0, 0, 64'h0,    0, NOP, 64'h0, 0));
    // basic fetch
    vecs.push_back(mk(0, 1, A,        0, 0, 0, 0, 32'h0,        0,   1, 1, A,        0, NOP, 64'h0, 0));
    vecs.push_back(mk(0, 1, A,        0, 0, 1, 0, 32'h0,        0,   1, 0, A,        0, NOP, 64'h0, 0));
    vecs.push_back(mk(0, 0, A,        0, 0, 0, 0, 32'h0,        0,   1, 0, A,        0, NOP, 64'h0, 0));
    vecs.push_back(mk(0, 0, A,        0, 0, 0, 1, I1,           0,   0, 0, A,        1, I1,  A,     0));
    vecs.push_back(mk(0, 0, A,        0, 0, 0, 0, 32'h0,        0,   0, 0, A,        0, I1,  A,     0));
    // redirect in WAIT, stale response dropped, refetch
    vecs.push_back(mk(0, 1, A+'h40,   0, 0, 0, 0, 32'h0,        0,   1, 1, A+'h40,   0, I1,  A,     0));
    vecs.push_back(mk(0, 0, A+'h40,   0, 0, 1, 0, 32'h0,        0,   1, 0, A+'h40,   0, I1,  A,     0));
    vecs.push_back(mk(0, 0, A+'h40,   1, 0, 0, 0, 32'h0,        0,   1, 0, A+'h40,   0, I1,  A,     0));
    vecs.push_back(mk(0, 0, A+'h40,   0, 0, 0, 0, 32'h0,        0,   1, 0, A+'h40,   0, I1,  A,     0));
    vecs.push_back(mk(0, 0, A+'h40,   0, 0, 0, 0, 32'h0,        0,   1, 0, A+'h40,   0, I1,  A,     0));
    vecs.push_back(mk(0, 0, A+'h40,   0, 0, 0, 1, 32'hDEADBEEF, 0,   0, 0, A+'h40,   0, I1,  A,     0));
    vecs.push_back(mk(0, 1, A+'h100,  0, 0, 0, 0, 32'h0,        0,   1, 1, A+'h100,  0, I1,  A,     0));
    vecs.push_back(mk(0, 0, A+'h100,  0, 0, 1, 0, 32'h0,        0,   1, 0, A+'h100,  0, I1,  A,     0));
    vecs.push_back(mk(0, 0, A+'h100,  0, 0, 0, 1, I2,           0,   0, 0, A+'h100,  1, I2,  A+'h100, 0));
    vecs.push_back(mk(0, 0, A+'h100,  0, 0, 0, 0, 32'h0,        0,   0, 0, A+'h100,  0, I2,  A+'h100, 0));
    // bus error
    vecs.push_back(mk(0, 1, A+'h200,  0, 0, 0, 0, 32'h0,        0,   1, 1, A+'h200,  0, I2,  A+'h100, 0));
    vecs.push_back(mk(0, 0, A+'h200,  0, 0, 1, 0, 32'h0,        0,   1, 0, A+'h200,  0, I2,  A+'h100, 0));
    vecs.push_back(mk(0, 0, A+'h200,  0, 0, 0, 1, 32'h12345678, 1,   0, 0, A+'h200,  0, I2,  A+'h100, 1));
    vecs.push_back(mk(0, 0, A+'h200,  0, 0, 0, 0, 32'h0,        0,   0, 0, A+'h200,  0, I2,  A+'h100, 0));
    // redirect in REQ keeps valid up, then drops the response
    vecs.push_back(mk(0, 1, A+'h300,  0, 0, 0, 0, 32'h0,        0,   1, 1, A+'h300,  0, I2,  A+'h100, 0));
    vecs.push_back(mk(0, 0, A+'h300,  1, 0, 0, 0, 32'h0,        0,   1, 1, A+'h300,  0, I2,  A+'h100, 0));
    vecs.push_back(mk(0, 0, A+'h300,  0, 0, 1, 0, 32'h0,        0,   1, 0, A+'h300,  0, I2,  A+'h100, 0));
    vecs.push_back(mk(0, 0, A+'h300,  0, 0, 0, 1, 32'h0000AAAA, 1,   0, 0, A+'h300,  0, I2,  A+'h100, 0));
    // redirect in IDLE blocks launch; stray response in IDLE ignored
    vecs.push_back(mk(0, 1, A,        1, 0, 0, 0, 32'h0,        0,   0, 0, A+'h300,  0, I2,  A+'h100, 0));
    vecs.push_back(mk(0, 0, A,        0, 0, 0, 1, 32'h00005555, 0,   0, 0, A+'h300,  0, I2,  A+'h100, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].rd, vecs[i].st, vecs[i].rdy,
          vecs[i].rv, vecs[i].data, vecs[i].err);
      chk_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_rqv, vecs[i].e_addr,
              vecs[i].e_iv, vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_fault);
    end

    // backpressure: request held stable while pc_in wiggles
    cyc(0, 1, A, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, A + 64'(i * 4 + 4), 0, 0, 0, 0, 32'h0, 0);
      chk($sformatf("bp%0d.valid", i), 64'(mem_req_valid), 64'h1);
      chk($sformatf("bp%0d.addr", i), mem_req_addr, A);
    end
    cyc(0, 0, 64'h0, 0, 0, 1, 0, 32'h0, 0);
    chk("bp.valid_fall", 64'(mem_req_valid), 64'h0);

    // response under decode stall parks in HOLD for 4 stalled cycles
    cyc(0, 0, 64'h0, 0, 1, 0, 1, I3, 0);
    chk("hold.stall", 64'(fetch_stall), 64'h1);
    chk("hold.iv", 64'(inst_valid), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 64'h0, 0, 1, 0, 0, 32'h0, 0);
      chk($sformatf("hold%0d.iv", i), 64'(inst_valid), 64'h0);
      chk($sformatf("hold%0d.inst", i), 64'(inst_out), 64'(I2));
    end
    idle_cyc();
    chk_all("hold.release", 0, 0, A, 1, I3, A, 0);
    idle_cyc();
    chk("hold.pulse_end", 64'(inst_valid), 64'h0);

    // redirect while in HOLD discards the parked instruction
    cyc(0, 1, A+'h600, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 64'h0, 0, 0, 1, 0, 32'h0, 0);
    cyc(0, 0, 64'h0, 0, 1, 0, 1, 32'h0BAD0BAD, 0);
    cyc(0, 0, 64'h0, 1, 1, 0, 0, 32'h0, 0);
    chk_all("hold_redir", 0, 0, A+'h600, 0, I3, A, 0);
    idle_cyc();
    chk("hold_redir.iv", 64'(inst_valid), 64'h0);

    // timeout: fault 8 cycles after the handshake
    cyc(0, 1, A+'h400, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 64'h0, 0, 0, 1, 0, 32'h0, 0);
    for (int k = 1; k < 8; k++) begin
      idle_cyc();
      chk($sformatf("to%0d.fault", k), 64'(fault), 64'h0);
      chk($sformatf("to%0d.stall", k), 64'(fetch_stall), 64'h1);
    end
    idle_cyc();
    chk("to8.fault", 64'(fault), 64'h1);
    chk("to8.stall", 64'(fetch_stall), 64'h0);
    idle_cyc();
    chk("to9.fault", 64'(fault), 64'h0);

    // reset mid-transaction, then a late response
    cyc(0, 1, A+'h500, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 64'h0, 0, 0, 1, 0, 32'h0, 0);
    idle_cyc();
    cyc(1, 0, 64'h0, 0, 0, 0, 0, 32'h0, 0);
    chk_all("rst_mid", 0, 0, 64'h0, 0, NOP, 64'h0, 0);
    cyc(0, 0, 64'h0, 0, 0, 0, 1, 32'h0BADBEEF, 0);
    chk_all("late_resp", 0, 0, 64'h0, 0, NOP, 64'h0, 0);
    idle_cyc();
    chk_all("late_resp2", 0, 0, 64'h0, 0, NOP, 64'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
